gate_tester: RTL and testbench

Self-checking stimulus driver for a 2-input combinational gate: on a start pulse it drives all four input vectors onto the gate, waits a settle interval per vector, samples the gate output, and compares it against a programmable truth table. It sits on the opposite side of the gate interface, as the initiator that drives `a`/`b` and consumes `c`. Used as the on-board self-test for the lab gate designs (AND/OR/XOR/NAND).

---
 rtl/gate_test_pkg.sv | 19 +
 rtl/gate_tester.sv | 95 +++++++++
 tb/tb_gate_tester.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate self-test driver: FSM states, vector count
// and truth tables for the lab gates. Truth-table bit index is {a,b}.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_VECTORS = 4;

  localparam logic [NUM_VECTORS-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VECTORS-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VECTORS-1:0] TT_XOR  = 4'b0110;
  localparam logic [NUM_VECTORS-1:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_tester.sv
// On a start pulse, walks {a,b} through 00..11, holds each vector SETTLE_CYCLES
// cycles, samples gate_c once, and records mismatches against EXPECT.
module gate_tester
  import gate_test_pkg::*;
#(
  parameter int                     SETTLE_CYCLES = 2,
  parameter logic [NUM_VECTORS-1:0] EXPECT        = TT_AND
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   gate_a,
  output logic                   gate_b,
  input  logic                   gate_c,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] fail_vec,
  output state_e                 dbg_state
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [1:0]             vec_q, vec_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_VECTORS-1:0] fail_q, fail_d;
  logic                   pass_q, pass_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = '0;
          cnt_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        fail_d[vec_q] = (gate_c != EXPECT[vec_q]);
        if (vec_q == 2'd3) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      DONE: begin
        // fail_q already holds the last vector's result, written in SAMPLE
        pass_d  = ~|fail_q;
        vec_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gate_a    = vec_q[1];
  assign gate_b    = vec_q[0];
  assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign fail_vec  = fail_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: three instances with different settle/truth-table
// settings, each driving a selectable behavioural gate.
module tb_gate_tester;
  import gate_test_pkg::*;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [N];
  logic       ga [N], gb [N], gc [N];
  logic       busy [N], done [N], pass [N];
  logic [3:0] fv [N];
  state_e     dbg [N];
  int         gsel [N];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  logic [1:0] seq [64];

  always #5 clk = ~clk;

  gate_tester #(.SETTLE_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .gate_a(ga[0]), .gate_b(gb[0]),
    .gate_c(gc[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_vec(fv[0]), .dbg_state(dbg[0]));
  gate_tester #(.SETTLE_CYCLES(1), .EXPECT(TT_AND)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .gate_a(ga[1]), .gate_b(gb[1]),
    .gate_c(gc[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_vec(fv[1]), .dbg_state(dbg[1]));
  gate_tester #(.SETTLE_CYCLES(3), .EXPECT(TT_OR)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .gate_a(ga[2]), .gate_b(gb[2]),
    .gate_c(gc[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .fail_vec(fv[2]), .dbg_state(dbg[2]));

  // 0=AND 1=OR 2=XOR 3=NAND other=tied low
  function automatic logic gate_fn(int sel, logic a, logic b);
    case (sel)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~(a & b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int s_of(int i);
    case (i)
      0: return 2;
      1: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic logic [3:0] exp_of(int i);
    return (i == 2) ? TT_OR : TT_AND;
  endfunction

  function automatic logic [3:0] full_fail(int i);
    logic [3:0] tt;
    logic [3:0] r;
    tt = exp_of(i);
    r  = '0;
    for (int v = 0; v < 4; v++) begin
      logic [1:0] vv;
      vv   = 2'(v);
      r[v] = gate_fn(gsel[i], vv[1], vv[0]) != tt[v];
    end
    return r;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_gate
    assign gc[g] = gate_fn(gsel[g], ga[g], gb[g]);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: each run is a timeline of 4*(S+1) busy cycles then one done cycle.
  bit         m_run  [N];
  int         m_t    [N];
  logic [3:0] m_fail [N];
  logic [3:0] m_full [N];
  logic       m_pass [N];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_run[i]  <= 1'b0;
        m_fail[i] <= '0;
        m_pass[i] <= 1'b0;
      end else if (!m_run[i] && start[i]) begin
        m_run[i]  <= 1'b1;
        m_t[i]    <= 0;
        m_fail[i] <= '0;
        m_pass[i] <= 1'b0;
        m_full[i] <= full_fail(i);
      end else if (m_run[i]) begin
        if (m_t[i] == 4 * (s_of(i) + 1)) begin
          m_run[i]  <= 1'b0;
          m_fail[i] <= m_full[i];
          m_pass[i] <= (m_full[i] == 4'b0000);
        end else begin
          m_t[i] <= m_t[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        int s, lim, v;
        logic e_busy, e_done, e_pass;
        logic [3:0] e_fail;
        s   = s_of(i);
        lim = 4 * (s + 1);
        if (m_run[i]) begin
          e_busy = m_t[i] < lim;
          e_done = m_t[i] == lim;
          v      = m_t[i] / (s + 1);
          if (v > 3) v = 3;
          e_fail = '0;
          for (int j = 0; j < 4; j++)
            if (m_t[i] > j * (s + 1) + s) e_fail[j] = m_full[i][j];
          e_pass = 1'b0;
        end else begin
          e_busy = 1'b0;
          e_done = 1'b0;
          v      = 0;
          e_fail = m_fail[i];
          e_pass = m_pass[i];
        end
        chk($sformatf("u%0d.busy", i), int'(busy[i]), int'(e_busy));
        chk($sformatf("u%0d.done", i), int'(done[i]), int'(e_done));
        chk($sformatf("u%0d.vec", i), int'({ga[i], gb[i]}), v);
        chk($sformatf("u%0d.fail_vec", i), int'(fv[i]), int'(e_fail));
        chk($sformatf("u%0d.pass", i), int'(pass[i]), int'(e_pass));
      end
    end
  end

  // Pulses start, optionally re-pulses it at run offset pulse_at, returns done offset.
  task automatic run(input int i, input int pulse_at, output int lat);
    int acc;
    lat = -1;
    @(negedge clk) start[i] = 1'b1;
    @(negedge clk) start[i] = 1'b0;
    acc = cyc;
    for (int k = 0; k < 80; k++) begin
      if (cyc - acc < 64) seq[cyc - acc] = {ga[i], gb[i]};
      if (done[i]) begin
        lat = cyc - acc;
        break;
      end
      @(negedge clk);
      start[i] = (pulse_at >= 0) && (cyc - acc == pulse_at);
    end
    start[i] = 1'b0;
    if (lat < 0) chk($sformatf("u%0d.done_timeout", i), 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int lat, acc, d1, d2, extra;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0;
      gsel[i]  = 0;
    end
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset.busy", int'(busy[0]), 0);
    chk("reset.fail_vec", int'(fv[0]), 0);
    chk("reset.state_idle", int'(dbg[0] == IDLE), 1);
    rst = 1'b0;

    // AND gate, defaults: done at cycle 13 (12 edges after accept)
    run(0, -1, lat);
    chk("and.done_cycle", lat, 12);
    chk("and.vec_t0", int'(seq[0]), 0);
    chk("and.vec_t3", int'(seq[3]), 1);
    chk("and.vec_t6", int'(seq[6]), 2);
    chk("and.vec_t11", int'(seq[11]), 3);
    chk("and.pass", int'(pass[0]), 1);
    chk("and.fail_vec", int'(fv[0]), 0);

    gsel[0] = 1;
    run(0, -1, lat);
    chk("or_vs_and.fail_vec", int'(fv[0]), 4'b0110);
    chk("or_vs_and.pass", int'(pass[0]), 0);

    gsel[0] = 4;
    run(0, -1, lat);
    chk("tie0.fail_vec", int'(fv[0]), 4'b1000);
    chk("tie0.pass", int'(pass[0]), 0);

    gsel[0] = 2;
    run(0, -1, lat);
    chk("xor_vs_and.fail_vec", int'(fv[0]), 4'b1110);

    // SETTLE_CYCLES=1 with a stray start while busy
    run(1, 3, lat);
    chk("s1.done_cycle", lat, 8);
    chk("s1.pass", int'(pass[1]), 1);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done[1]) extra++;
    end
    chk("s1.no_second_done", extra, 0);

    // SETTLE_CYCLES=3, EXPECT=OR
    gsel[2] = 1;
    run(2, -1, lat);
    chk("s3or.done_cycle", lat, 16);
    chk("s3or.pass", int'(pass[2]), 1);
    gsel[2] = 0;
    run(2, -1, lat);
    chk("s3or_and.fail_vec", int'(fv[2]), 4'b0110);

    // start held high: back-to-back runs
    gsel[0] = 0;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk);
    acc = cyc;
    d1 = -1;
    d2 = -1;
    for (int k = 0; k < 30; k++) begin
      if (done[0]) begin
        if (d1 < 0) d1 = cyc - acc;
        else if (d2 < 0) d2 = cyc - acc;
      end
      @(negedge clk);
    end
    start[0] = 1'b0;
    chk("b2b.first_done", d1, 12);
    chk("b2b.second_done", d2, 26);
    repeat (30) @(negedge clk);

    // Reset mid-run
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.busy_before", int'(busy[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst.busy", int'(busy[0]), 0);
    chk("rst.vec", int'({ga[0], gb[0]}), 0);
    chk("rst.done", int'(done[0]), 0);
    chk("rst.fail_vec", int'(fv[0]), 0);
    chk("rst.pass", int'(pass[0]), 0);
    rst = 1'b0;
    run(0, -1, lat);
    chk("rst.rerun_done_cycle", lat, 12);
    chk("rst.rerun_pass", int'(pass[0]), 1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
